ram_burst_master: RTL and testbench

//  Initiator side of the 8x8 single-write / sync-read RAM port (we, inaddr, outaddr, din, dout).

---
 rtl/ram_burst_master_if.sv | 45 ++++
 rtl/ram_burst_master.sv | 142 ++++++++++++++
 tb/tb_ram_burst_master.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_burst_master_if.sv
// Burst-master bus bundle: command channel, write/read data streams and the
// single-write / sync-read RAM port.
interface ram_burst_master_if #(
    parameter int AW = 3,
    parameter int DW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic          wr_data_valid;
    logic          wr_data_ready;
    logic [DW-1:0] wr_data;
    logic          rd_data_valid;
    logic          rd_data_ready;
    logic [DW-1:0] rd_data;
    logic          ram_we;
    logic [AW-1:0] ram_inaddr;
    logic [AW-1:0] ram_outaddr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        output cmd_ready,
        input  wr_data_valid, wr_data,
        output wr_data_ready,
        output rd_data_valid, rd_data,
        input  rd_data_ready,
        output ram_we, ram_inaddr, ram_outaddr, ram_din,
        input  ram_dout
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  cmd_ready,
        output wr_data_valid, wr_data,
        input  wr_data_ready,
        input  rd_data_valid, rd_data,
        output rd_data_ready,
        input  ram_we, ram_inaddr, ram_outaddr, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-write / sync-read RAM with wrap-around addressing.
// Optional feature macro RBM_CHECKSUM_EN adds the burst_sum accumulator output.
module ram_burst_master #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ram_burst_master_if.master   bus,
`ifdef RBM_CHECKSUM_EN
    output logic [DW-1:0]        burst_sum,
`endif
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_CAP, RD_OUT} state_t;

    state_t        state_r, state_s;
    logic [AW-1:0] addr_r, addr_s;
    logic [AW-1:0] cnt_r, cnt_s;
    logic [DW-1:0] rd_data_r, rd_data_s;
    logic          done_r, done_s;
    logic          wr_hs_s, rd_hs_s, cmd_hs_s;

    assign cmd_hs_s = (state_r == IDLE) && bus.cmd_valid;
    assign wr_hs_s  = (state_r == WR) && bus.wr_data_valid;
    assign rd_hs_s  = (state_r == RD_OUT) && bus.rd_data_ready;

    // Write strobe is gated by rst_n so a reset landing mid-burst never writes.
    assign bus.cmd_ready     = (state_r == IDLE);
    assign bus.wr_data_ready = (state_r == WR) && rst_n;
    assign bus.ram_we        = wr_hs_s && rst_n;
    assign bus.ram_inaddr    = addr_r;
    assign bus.ram_din       = bus.wr_data;
    assign bus.ram_outaddr   = addr_r;
    assign bus.rd_data_valid = (state_r == RD_OUT);
    assign bus.rd_data       = rd_data_r;
    assign busy              = (state_r != IDLE);
    assign done              = done_r;

    // Next-state, address/count advance and read capture.
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        cnt_s     = cnt_r;
        rd_data_s = rd_data_r;
        done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_s  = bus.cmd_addr;
                    cnt_s   = bus.cmd_len;
                    state_s = bus.cmd_write ? WR : RD_REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            WR: begin
                if (wr_hs_s) begin
                    if (cnt_r == {AW{1'b0}}) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        addr_s = addr_r + AW'(1);
                        cnt_s  = cnt_r - AW'(1);
                    end
                end else begin
                    state_s = WR;
                end
            end
            RD_REQ: state_s = RD_CAP;
            RD_CAP: begin
                rd_data_s = bus.ram_dout;
                state_s   = RD_OUT;
            end
            RD_OUT: begin
                if (rd_hs_s) begin
                    if (cnt_r == {AW{1'b0}}) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        addr_s  = addr_r + AW'(1);
                        cnt_s   = cnt_r - AW'(1);
                        state_s = RD_REQ;
                    end
                end else begin
                    state_s = RD_OUT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            addr_r    <= {AW{1'b0}};
            cnt_r     <= {AW{1'b0}};
            rd_data_r <= {DW{1'b0}};
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            addr_r    <= addr_s;
            cnt_r     <= cnt_s;
            rd_data_r <= rd_data_s;
            done_r    <= done_s;
        end
    end

`ifdef RBM_CHECKSUM_EN
    logic [DW-1:0] sum_r, sum_s;

    // Running modular sum of words moved in the current burst.
    always_comb begin
        sum_s = sum_r;
        if (cmd_hs_s) begin
            sum_s = {DW{1'b0}};
        end else if (wr_hs_s) begin
            sum_s = sum_r + bus.wr_data;
        end else if (rd_hs_s) begin
            sum_s = sum_r + rd_data_r;
        end else begin
            sum_s = sum_r;
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_r <= {DW{1'b0}};
        end else begin
            sum_r <= sum_s;
        end
    end

    assign burst_sum = sum_r;
`else
    logic unused_cmd_hs_s;
    assign unused_cmd_hs_s = cmd_hs_s;
`endif
endmodule

// File: tb/tb_ram_burst_master.sv
// Directed self-checking bench for ram_burst_master with a sync-read RAM model.
module tb_ram_burst_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, done;
`ifdef RBM_CHECKSUM_EN
    logic [7:0] burst_sum;
`endif

    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    int done_count = 0;
    int base, dcnt, n, k;

    logic [2:0] log_addr [64];
    logic [7:0] log_data [64];
    logic [7:0] mem [8];
    logic [7:0] ram_dout_r = 8'h00;
    logic [7:0] d1 [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [3:0] pat = 4'b1001;
    logic [2:0] ea;

    ram_burst_master_if #(.AW(3), .DW(8)) bus ();

    ram_burst_master #(.AW(3), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
`ifdef RBM_CHECKSUM_EN
        .burst_sum (burst_sum),
`endif
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // RAM model: one write port, registered read port updated when not writing.
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_inaddr] <= bus.ram_din;
        else ram_dout_r <= mem[bus.ram_outaddr];
    end
    assign bus.ram_dout = ram_dout_r;

    always @(posedge clk) begin
        if (bus.ram_we) begin
            log_addr[wr_count] <= bus.ram_inaddr;
            log_data[wr_count] <= bus.ram_din;
            wr_count <= wr_count + 1;
        end
        if (done) done_count <= done_count + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 3'd0; bus.cmd_len = 3'd0;
        bus.wr_data_valid = 1'b0; bus.wr_data = 8'h00; bus.rd_data_ready = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;

        // Reset state
        tick(); tick();
        chk("rst_cmd_ready", bus.cmd_ready, 32'd1);
        chk("rst_busy", busy, 32'd0);
        chk("rst_done", done, 32'd0);
        chk("rst_wr_ready", bus.wr_data_ready, 32'd0);
        chk("rst_rd_valid", bus.rd_data_valid, 32'd0);
        chk("rst_rd_data", bus.rd_data, 32'h0);
        chk("rst_ram_we", bus.ram_we, 32'd0);
        rst_n = 1'b1;
        tick();

        // Test 1: wrapping write burst addr=6 len=3
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 3'd6; bus.cmd_len = 3'd3;
        tick();
        bus.cmd_valid = 1'b0;
        chk("t1_busy", busy, 32'd1);
        chk("t1_cmd_ready_busy", bus.cmd_ready, 32'd0);
        chk("t1_wr_ready", bus.wr_data_ready, 32'd1);
        chk("t1_we_idle", bus.ram_we, 32'd0);
        base = wr_count;
        for (int i = 0; i < 4; i++) begin
            bus.wr_data = d1[i]; bus.wr_data_valid = 1'b1;
            #1;
            if (i == 0) chk("t1_we_first", bus.ram_we, 32'd1);
            tick();
        end
        bus.wr_data_valid = 1'b0;
        chk("t1_done", done, 32'd1);
        chk("t1_cmd_ready_done", bus.cmd_ready, 32'd1);
        chk("t1_busy_end", busy, 32'd0);
`ifdef RBM_CHECKSUM_EN
        chk("t6_sum_write", burst_sum, 32'h0E);
`endif
        chk("t1_nwrites", wr_count - base, 32'd4);
        for (int i = 0; i < 4; i++) begin
            ea = 3'd6 + 3'(i);
            chk("t1_wr_addr", log_addr[base+i], 32'(ea));
            chk("t1_wr_data", log_data[base+i], 32'(d1[i]));
        end
        dcnt = done_count;
        tick();
        chk("t1_done_pulse", done, 32'd0);
        chk("t1_done_count", done_count - dcnt, 32'd1);

        // Test 2: read back addr=6 len=3
        bus.rd_data_ready = 1'b1;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 3'd6; bus.cmd_len = 3'd3;
        tick();
        bus.cmd_valid = 1'b0;
        for (int w = 0; w < 4; w++) begin
            n = 0;
            while (!bus.rd_data_valid && n < 8) begin tick(); n++; end
            ea = 3'd6 + 3'(w);
            chk("t2_rd_valid", bus.rd_data_valid, 32'd1);
            chk("t2_rd_data", bus.rd_data, 32'(d1[w]));
            chk("t2_latency", n, 32'd2);
            chk("t2_outaddr", bus.ram_outaddr, 32'(ea));
            tick();
        end
        chk("t2_done", done, 32'd1);
`ifdef RBM_CHECKSUM_EN
        chk("t6_sum_read", burst_sum, 32'h0E);
`endif
        tick();

        // Test 3: read with consumer stall of 5 cycles
        bus.rd_data_ready = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 3'd6; bus.cmd_len = 3'd1;
        tick();
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.rd_data_valid && n < 8) begin tick(); n++; end
        chk("t3_rd_valid", bus.rd_data_valid, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_stall_valid", bus.rd_data_valid, 32'd1);
            chk("t3_stall_data", bus.rd_data, 32'hAA);
            chk("t3_stall_outaddr", bus.ram_outaddr, 32'd6);
            chk("t3_stall_done", done, 32'd0);
        end
        bus.rd_data_ready = 1'b1;
        tick();
        n = 0;
        while (!bus.rd_data_valid && n < 8) begin tick(); n++; end
        chk("t3_resume_data", bus.rd_data, 32'hBB);
        chk("t3_resume_outaddr", bus.ram_outaddr, 32'd7);
        tick();
        chk("t3_done", done, 32'd1);
        tick();

        // Test 4: write len=1 with valid gaps 1,0,0,1
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 3'd2; bus.cmd_len = 3'd1;
        tick();
        bus.cmd_valid = 1'b0;
        base = wr_count;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            bus.wr_data_valid = pat[3-i];
            bus.wr_data = (k == 0) ? 8'h11 : 8'h22;
            #1;
            chk("t4_we_pattern", bus.ram_we, 32'(pat[3-i]));
            if (pat[3-i]) k++;
            tick();
        end
        bus.wr_data_valid = 1'b0;
        chk("t4_done", done, 32'd1);
        chk("t4_nwrites", wr_count - base, 32'd2);
        chk("t4_addr0", log_addr[base], 32'd2);
        chk("t4_data0", log_data[base], 32'h11);
        chk("t4_addr1", log_addr[base+1], 32'd3);
        chk("t4_data1", log_data[base+1], 32'h22);
        tick();

        // Test 5: reset in the middle of a write burst
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 3'd4; bus.cmd_len = 3'd3;
        tick();
        bus.cmd_valid = 1'b0;
        base = wr_count;
        bus.wr_data_valid = 1'b1;
        bus.wr_data = 8'h44; tick();
        bus.wr_data = 8'h55; tick();
        bus.wr_data = 8'h66; rst_n = 1'b0;
        #1;
        chk("t5_we_in_reset", bus.ram_we, 32'd0);
        dcnt = done_count;
        tick();
        chk("t5_busy", busy, 32'd0);
        chk("t5_cmd_ready", bus.cmd_ready, 32'd1);
        chk("t5_done", done, 32'd0);
        chk("t5_we", bus.ram_we, 32'd0);
        rst_n = 1'b1; bus.wr_data_valid = 1'b0;
        tick();
        chk("t5_no_done", done, 32'd0);
        chk("t5_done_count", done_count - dcnt, 32'd0);
        chk("t5_nwrites", wr_count - base, 32'd2);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 3'd4; bus.cmd_len = 3'd0;
        tick();
        bus.cmd_valid = 1'b0;
        chk("t5_new_cmd_busy", busy, 32'd1);
        n = 0;
        while (!bus.rd_data_valid && n < 8) begin tick(); n++; end
        chk("t5_readback", bus.rd_data, 32'h44);
        tick();
        chk("t5_read_done", done, 32'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
